// File: rtl/gelato_ifetch_unit.sv
// gelato_ifetch_unit: single-outstanding instruction fetch stage between warp scheduler and I-Decode
module gelato_ifetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WARP_NUM_WIDTH = 5,
  parameter int SPLIT_NUM_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       sched_valid,
  output logic                       sched_ready,
  input  logic [ADDR_WIDTH-1:0]      sched_pc,
  input  logic [WARP_NUM_WIDTH-1:0]  sched_warp_num,
  input  logic [SPLIT_NUM_WIDTH-1:0] sched_split_table_num,
  output logic                       icache_req_valid,
  input  logic                       icache_req_ready,
  output logic [ADDR_WIDTH-1:0]      icache_req_addr,
  input  logic                       icache_resp_valid,
  input  logic [DATA_WIDTH-1:0]      icache_resp_data,
  output logic                       idecode_valid,
  input  logic                       idecode_ready,
  output logic [ADDR_WIDTH-1:0]      idecode_pc,
  output logic [WARP_NUM_WIDTH-1:0]  idecode_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0] idecode_split_table_num,
  output logic [DATA_WIDTH-1:0]      idecode_inst,
  output logic                       idecode_fault
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;
  state_t state, state_nxt;
  logic accept, misaligned;
  assign misaligned = |sched_pc[1:0];
  assign icache_req_valid = state == REQ;
  assign icache_req_addr = idecode_pc;
  assign idecode_valid = state == HOLD;
  always_comb begin
    sched_ready = rst_n && !flush && (state == IDLE || (state == HOLD && idecode_ready));
    accept = sched_valid && sched_ready;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (misaligned ? HOLD : REQ) : IDLE;
      REQ:     state_nxt = icache_req_ready ? (flush ? DRAIN : WAIT) : (flush ? IDLE : REQ);
      WAIT:    state_nxt = icache_resp_valid ? (flush ? IDLE : HOLD) : (flush ? DRAIN : WAIT);
      DRAIN:   state_nxt = icache_resp_valid ? IDLE : DRAIN;
      HOLD:    state_nxt = flush ? IDLE : accept ? (misaligned ? HOLD : REQ) : idecode_ready ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idecode_pc <= '0;
      idecode_warp_num <= '0;
      idecode_split_table_num <= '0;
      idecode_inst <= '0;
      idecode_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idecode_pc <= sched_pc;
        idecode_warp_num <= sched_warp_num;
        idecode_split_table_num <= sched_split_table_num;
        idecode_inst <= '0;
        idecode_fault <= misaligned;
      end else if (state == WAIT && icache_resp_valid && !flush) begin
        idecode_inst <= icache_resp_data;
      end
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) icache_resp_valid |-> (state == WAIT || state == DRAIN));
endmodule

// File: tb/tb_gelato_ifetch_unit.sv
// tb_gelato_ifetch_unit: randomized and directed checks against a transaction-level fetch model
module tb_gelato_ifetch_unit;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, sched_valid = 1'b0;
  logic icache_req_ready = 1'b0, icache_resp_valid = 1'b0, idecode_ready = 1'b0;
  logic [31:0] sched_pc = '0, icache_resp_data = '0;
  logic [4:0] sched_warp_num = '0;
  logic [3:0] sched_split_table_num = '0;
  logic sched_ready, icache_req_valid, idecode_valid, idecode_fault;
  logic [31:0] icache_req_addr, idecode_pc, idecode_inst;
  logic [4:0] idecode_warp_num;
  logic [3:0] idecode_split_table_num;
  int n_tot = 0, n_pass = 0;
  bit m_req, m_out, m_disc, m_held, m_fault, acc;
  logic [31:0] m_pc, m_inst, word, next_word;
  logic [4:0] m_warp;
  logic [3:0] m_split;
  int cnt = 0, lat = 1;
  always #5 clk = ~clk;
  gelato_ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_pc(sched_pc),
    .sched_warp_num(sched_warp_num), .sched_split_table_num(sched_split_table_num),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_resp_valid(icache_resp_valid),
    .icache_resp_data(icache_resp_data), .idecode_valid(idecode_valid),
    .idecode_ready(idecode_ready), .idecode_pc(idecode_pc),
    .idecode_warp_num(idecode_warp_num), .idecode_split_table_num(idecode_split_table_num),
    .idecode_inst(idecode_inst), .idecode_fault(idecode_fault)
  );
  function automatic bit exp_ready();
    return rst_n && !flush && !m_req && !m_out && (!m_held || idecode_ready);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 0; m_out = 0; m_disc = 0; m_held = 0; m_fault = 0;
      m_pc = '0; m_inst = '0; m_warp = '0; m_split = '0; cnt = 0; word = '0;
    end else begin
      acc = sched_valid && exp_ready();
      if (cnt > 0) cnt--;
      if (m_held && (flush || idecode_ready)) m_held = 0;
      if (m_out && icache_resp_valid) begin
        m_out = 0;
        if (!flush && !m_disc) begin m_held = 1; m_inst = icache_resp_data; m_fault = 0; end
      end else if (m_out && flush) m_disc = 1;
      if (m_req && icache_req_ready) begin
        m_req = 0; m_out = 1; m_disc = flush; cnt = lat; word = next_word;
      end else if (m_req && flush) m_req = 0;
      if (acc) begin
        m_pc = sched_pc; m_warp = sched_warp_num; m_split = sched_split_table_num;
        if (|sched_pc[1:0]) begin m_held = 1; m_fault = 1; m_inst = '0; end
        else m_req = 1;
      end
    end
  end
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  task automatic chkb(string n, logic got, logic exp);
    chk(n, 32'(got), 32'(exp));
  endtask
  task automatic nxt();
    @(negedge clk);
    flush = 1'b0;
    icache_resp_valid = cnt == 1;
    icache_resp_data = icache_resp_valid ? word : $urandom();
  endtask
  task automatic cmp();
    #1;
    chkb("sched_ready", sched_ready, exp_ready());
    chkb("req_valid", icache_req_valid, m_req);
    if (m_req) chk("req_addr", icache_req_addr, m_pc);
    chkb("idecode_valid", idecode_valid, m_held);
    if (m_held) begin
      chk("idecode_pc", idecode_pc, m_pc);
      chk("idecode_warp", 32'(idecode_warp_num), 32'(m_warp));
      chk("idecode_split", 32'(idecode_split_table_num), 32'(m_split));
      chk("idecode_inst", idecode_inst, m_inst);
      chkb("idecode_fault", idecode_fault, m_fault);
    end
  endtask
  task automatic settle();
    idecode_ready = 1'b1; sched_valid = 1'b0; icache_req_ready = 1'b1;
    repeat (8) begin nxt(); cmp(); end
  endtask
  task automatic fetch(logic [31:0] pc, logic [4:0] w, logic [3:0] s);
    sched_valid = 1'b1; sched_pc = pc; sched_warp_num = w; sched_split_table_num = s;
  endtask
  initial begin
    #2;
    chkb("reset sched_ready", sched_ready, 1'b0);
    chkb("reset idecode_valid", idecode_valid, 1'b0);
    chk("reset idecode_pc", idecode_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nxt(); fetch(32'h80, 5'd3, 4'd2); lat = 1; next_word = 32'h00A00093;
    icache_req_ready = 1'b1; idecode_ready = 1'b0; cmp();
    chkb("t2 accept", sched_ready, 1'b1);
    nxt(); sched_valid = 1'b0; cmp();
    chkb("t2 req N+1", icache_req_valid, 1'b1);
    chk("t2 addr", icache_req_addr, 32'h80);
    nxt(); cmp();
    chkb("t2 no valid N+2", idecode_valid, 1'b0);
    nxt(); cmp();
    chkb("t2 valid N+3", idecode_valid, 1'b1);
    chk("t2 pc", idecode_pc, 32'h80);
    chk("t2 warp", 32'(idecode_warp_num), 32'd3);
    chk("t2 split", 32'(idecode_split_table_num), 32'd2);
    chk("t2 inst", idecode_inst, 32'h00A00093);
    repeat (5) begin
      nxt(); cmp();
      chk("t3 stall inst", idecode_inst, 32'h00A00093);
    end
    nxt(); idecode_ready = 1'b1; fetch(32'h84, 5'd3, 4'd2); cmp();
    chkb("t3 accept", sched_ready, 1'b1);
    nxt(); idecode_ready = 1'b0; sched_valid = 1'b0; cmp();
    chkb("t3 req", icache_req_valid, 1'b1);
    chk("t3 addr", icache_req_addr, 32'h84);
    settle();
    nxt(); lat = 3; fetch(32'h90, 5'd7, 4'd1); idecode_ready = 1'b0; cmp();
    nxt(); sched_valid = 1'b0; cmp();
    nxt(); flush = 1'b1; cmp();
    nxt(); sched_valid = 1'b1; cmp();
    chkb("t4 drain ready", sched_ready, 1'b0);
    nxt(); cmp();
    chkb("t4 resp ready", sched_ready, 1'b0);
    chkb("t4 resp seen", icache_resp_valid, 1'b1);
    chkb("t4 no valid", idecode_valid, 1'b0);
    nxt(); sched_valid = 1'b0; cmp();
    chkb("t4 idle ready", sched_ready, 1'b1);
    chkb("t4 still no valid", idecode_valid, 1'b0);
    nxt(); fetch(32'h102, 5'd9, 4'd5); cmp();
    chkb("t5 no req", icache_req_valid, 1'b0);
    nxt(); sched_valid = 1'b0; cmp();
    chkb("t5 no req2", icache_req_valid, 1'b0);
    chkb("t5 valid", idecode_valid, 1'b1);
    chkb("t5 fault", idecode_fault, 1'b1);
    chk("t5 inst", idecode_inst, 32'h0);
    settle();
    nxt(); lat = 2; fetch(32'hA0, 5'd1, 4'd1); idecode_ready = 1'b0; cmp();
    nxt(); sched_valid = 1'b0; flush = 1'b1; cmp();
    chkb("t6 req at flush", icache_req_valid, 1'b1);
    nxt(); cmp();
    chkb("t6 drain ready", sched_ready, 1'b0);
    chkb("t6 req gone", icache_req_valid, 1'b0);
    nxt(); cmp();
    chkb("t6 drain resp ready", sched_ready, 1'b0);
    nxt(); cmp();
    chkb("t6 idle ready", sched_ready, 1'b1);
    chkb("t6 no valid", idecode_valid, 1'b0);
    nxt(); icache_req_ready = 1'b0; fetch(32'hB0, 5'd2, 4'd3); cmp();
    nxt(); sched_valid = 1'b0; flush = 1'b1; cmp();
    chkb("t6b req at flush", icache_req_valid, 1'b1);
    nxt(); cmp();
    chkb("t6b req dropped", icache_req_valid, 1'b0);
    chkb("t6b idle ready", sched_ready, 1'b1);
    repeat (3000) begin
      nxt();
      flush = $urandom_range(0, 9) == 0;
      sched_valid = $urandom_range(0, 2) != 0;
      sched_pc = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      sched_warp_num = 5'($urandom());
      sched_split_table_num = 4'($urandom());
      idecode_ready = $urandom_range(0, 1) == 1;
      icache_req_ready = $urandom_range(0, 1) == 1;
      lat = $urandom_range(1, 3);
      next_word = $urandom();
      cmp();
    end
    settle();
    nxt(); lat = 1; idecode_ready = 1'b0; fetch(32'h100, 5'd4, 4'd6); cmp();
    nxt(); sched_valid = 1'b0; cmp();
    nxt(); cmp();
    nxt(); cmp();
    chkb("t1 held before reset", idecode_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chkb("t1 idecode_valid", idecode_valid, 1'b0);
    chkb("t1 req_valid", icache_req_valid, 1'b0);
    chkb("t1 sched_ready", sched_ready, 1'b0);
    chk("t1 idecode_pc", idecode_pc, 32'h0);
    chkb("t1 fault", idecode_fault, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
